engine_scheduler: RTL and testbench

- Central controller for the Mandelbrot engine array.
- Dispatches pixel coordinate words from the coordinate generator to idle engines over the shared engine_addr/in_word/latch_en broadcast.
- Arbitrates the engines' service_req lines round-robin onto the shared tri-state result bus, and writes captured results into the frame buffer.
- Counts results per frame and flags frame completion.

---
 rtl/engine_scheduler.sv | 146 ++++++++++++++
 tb/tb_engine_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/engine_scheduler.sv
// Central scheduler for the Mandelbrot engine array: dispatches coordinate words to idle
// engines and drains engine results round-robin into the frame buffer.
module engine_scheduler #(
  parameter int NUM_ENGINES  = 16,
  parameter int ADDR_W       = 5,
  parameter int FRAME_PIXELS = 307200,
  parameter int CNT_W        = 19
) (
  input  logic                   Engine_CLK,
  input  logic                   eRST_n,
  input  logic                   run,
  input  logic                   coord_valid,
  input  logic [82:0]            coord_word,
  output logic                   coord_ready,
  output logic [ADDR_W-1:0]      engine_addr,
  output logic [82:0]            in_word,
  output logic                   latch_en,
  input  logic [NUM_ENGINES-1:0] available,
  input  logic [NUM_ENGINES-1:0] service_req,
  output logic [NUM_ENGINES-1:0] req_ack,
  input  logic [26:0]            out_word,
  input  logic                   fb_full,
  output logic                   fb_we,
  output logic [26:0]            fb_wdata,
  output logic [CNT_W-1:0]       results_cnt,
  output logic                   frame_done
);

  localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [NUM_ENGINES-1:0] ONE_HOT0 = NUM_ENGINES'(1);
  localparam logic [CNT_W-1:0]       LAST_PIX = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0]      LAST_ENG = ADDR_W'(NUM_ENGINES - 1);

  typedef enum logic [1:0] {D_IDLE, D_STROBE, D_SETTLE} d_state_t;
  typedef enum logic       {R_IDLE, R_ACK}              r_state_t;

  d_state_t          d_state, d_next;
  r_state_t          r_state, r_next;
  logic              disp_go, grant_go, rr_hit;
  logic [ADDR_W-1:0] free_idx, rr_idx, ack_idx, ptr;

  // ---------------- dispatch ----------------
  always_comb begin
    free_idx = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--)
      if (available[i]) free_idx = ADDR_W'(i);
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a latch.
  always_comb begin
    d_next  = d_state;
    disp_go = 1'b0;
    case (d_state)
      D_IDLE: if (run && coord_valid && |available) begin
        d_next  = D_STROBE;
        disp_go = 1'b1;
      end
      D_STROBE: d_next = D_SETTLE;
      // Dead cycle so the target's available drop is seen before the next selection.
      D_SETTLE: d_next = D_IDLE;
      default:  d_next = D_IDLE;
    endcase
  end

  assign latch_en    = (d_state == D_STROBE);
  assign coord_ready = (d_state == D_STROBE);

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Engine_CLK or negedge eRST_n) begin
    if (!eRST_n) begin
      d_state     <= D_IDLE;
      engine_addr <= '0;
      in_word     <= '0;
    end else begin
      d_state <= d_next;
      if (disp_go) begin
        engine_addr <= free_idx;
        in_word     <= coord_word;
      end
    end
  end

  // ---------------- result arbitration ----------------
  always_comb begin : rr_search
    int pos;
    rr_idx = '0;
    rr_hit = 1'b0;
    pos    = 0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      pos = int'(ptr) + i;
      if (pos >= NUM_ENGINES) pos = pos - NUM_ENGINES;
      if (!rr_hit && service_req[pos[IDX_W-1:0]]) begin
        rr_hit = 1'b1;
        rr_idx = ADDR_W'(pos);
      end
    end
  end

  // No grant while fb_we is high: the previous engine needs that cycle to drop service_req.
  always_comb begin
    r_next   = r_state;
    grant_go = 1'b0;
    case (r_state)
      R_IDLE: if (rr_hit && !fb_full && !fb_we) begin
        r_next   = R_ACK;
        grant_go = 1'b1;
      end
      R_ACK:   r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge Engine_CLK or negedge eRST_n) begin
    if (!eRST_n) begin
      r_state     <= R_IDLE;
      req_ack     <= '0;
      ack_idx     <= '0;
      ptr         <= '0;
      fb_we       <= 1'b0;
      fb_wdata    <= '0;
      results_cnt <= '0;
      frame_done  <= 1'b0;
    end else begin
      r_state    <= r_next;
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      if (grant_go) begin
        req_ack <= ONE_HOT0 << rr_idx;
        ack_idx <= rr_idx;
      end
      if (r_state == R_ACK) begin
        req_ack  <= '0;
        fb_we    <= 1'b1;
        fb_wdata <= out_word;
        ptr      <= (ack_idx == LAST_ENG) ? '0 : ack_idx + 1'b1;
        if (results_cnt == LAST_PIX) begin
          results_cnt <= '0;
          frame_done  <= 1'b1;
        end else begin
          results_cnt <= results_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_engine_scheduler.sv
// Self-checking bench for engine_scheduler: directed dispatch/arbitration/reset sequences,
// a round-robin vector table, and a randomized run against a transaction-level model.
module tb_engine_scheduler;

  localparam int N  = 16;
  localparam int AW = 5;
  localparam int FP = 4;
  localparam int CW = 19;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          coord_valid = 1'b0;
  logic [82:0]   coord_word = '0;
  logic          coord_ready;
  logic [AW-1:0] engine_addr;
  logic [82:0]   in_word;
  logic          latch_en;
  logic [N-1:0]  available = '0;
  logic [N-1:0]  service_req = '0;
  logic [N-1:0]  req_ack;
  wire  [26:0]   out_word;
  logic          fb_full = 1'b0;
  logic          fb_we;
  logic [26:0]   fb_wdata;
  logic [CW-1:0] results_cnt;
  logic          frame_done;

  logic [26:0]   bus_data [N];
  logic [26:0]   bus_sel;
  logic [N-1:0]  one_n = 1;
  int            cyc = 0;
  int            n_vec = 0;
  int            n_bad = 0;

  engine_scheduler #(.NUM_ENGINES(N), .ADDR_W(AW), .FRAME_PIXELS(FP), .CNT_W(CW)) dut (
    .Engine_CLK(clk), .eRST_n(rst_n), .run(run), .coord_valid(coord_valid),
    .coord_word(coord_word), .coord_ready(coord_ready), .engine_addr(engine_addr),
    .in_word(in_word), .latch_en(latch_en), .available(available),
    .service_req(service_req), .req_ack(req_ack), .out_word(out_word),
    .fb_full(fb_full), .fb_we(fb_we), .fb_wdata(fb_wdata),
    .results_cnt(results_cnt), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engines drive the shared bus only while granted.
  always_comb begin
    bus_sel = '0;
    for (int i = 0; i < N; i++) if (req_ack[i]) bus_sel = bus_data[i];
  end
  assign out_word = (req_ack != '0) ? bus_sel : 27'bz;

  typedef struct {
    logic [N-1:0] req;
    logic [7:0]   iter;
    int           grant;
  } rr_vec_t;
  rr_vec_t tbl [9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [26:0] word_of(input int i, input logic [7:0] iter);
    return {10'(i * 3 + 5), 9'(i + 7), iter};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int lowest(input logic [N-1:0] a);
    for (int i = 0; i < N; i++) if (a[i]) return i;
    return 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; coord_valid = 1'b0; available = '0;
    service_req = '0; fb_full = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (req_ack != '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_latch(input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (latch_en) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          n, t1, last_ack;
    logic [82:0] c1, c2;
    // random-phase model state
    int          d_wait, e_ack, m_ptr, e_cnt;
    logic        e_latch, e_we, e_done;
    logic [AW-1:0] e_addr;
    logic [82:0] e_in;
    logic [26:0] e_wdata;

    tbl[0] = '{16'h8001, 8'h2A, 0};
    tbl[1] = '{16'h8001, 8'h2A, 15};
    tbl[2] = '{16'h8001, 8'h2A, 0};
    tbl[3] = '{16'h0010, 8'h11, 4};
    tbl[4] = '{16'h0011, 8'h22, 0};
    tbl[5] = '{16'h0002, 8'h33, 1};
    tbl[6] = '{16'hFFFF, 8'h44, 2};
    tbl[7] = '{16'h0008, 8'h55, 3};
    tbl[8] = '{16'h0001, 8'h66, 0};
    for (int i = 0; i < N; i++) bus_data[i] = '0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst req_ack", req_ack, 0);
    check("rst latch_en", latch_en, 0);
    check("rst coord_ready", coord_ready, 0);
    check("rst fb_we", fb_we, 0);
    check("rst results_cnt", results_cnt, 0);
    check("rst frame_done", frame_done, 0);
    check("rst engine_addr", engine_addr, 0);
    check("rst in_word", in_word, 0);
    rst_n = 1'b1;

    // ---- dispatch ----
    c1 = {10'd100, 9'd50, 32'h0123_4567, 32'h89AB_CDEF};
    c2 = {10'd101, 9'd51, 32'h7654_3210, 32'hFEDC_BA98};
    run = 1'b1; coord_valid = 1'b1; coord_word = c1; available = '0;
    n = 0;
    repeat (5) begin @(negedge clk); if (latch_en || coord_ready) n++; end
    check("no dispatch without available", n, 0);
    available = 16'h0030;
    wait_latch(10, ok);
    if (!ok) check("dispatch1 timeout", 0, 1);
    else begin
      t1 = cyc;
      check("dispatch1 engine_addr", engine_addr, 4);
      check("dispatch1 coord_ready", coord_ready, 1);
      check("dispatch1 in_word", in_word, c1);
      available = 16'h0020;
      coord_word = c2;
      @(negedge clk);
      check("dispatch1 latch width", latch_en, 0);
      check("dispatch1 ready width", coord_ready, 0);
      wait_latch(10, ok);
      if (!ok) check("dispatch2 timeout", 0, 1);
      else begin
        check("dispatch spacing", cyc - t1, 3);
        check("dispatch2 engine_addr", engine_addr, 5);
        check("dispatch2 in_word", in_word, c2);
      end
    end
    run = 1'b0;
    available = '1;
    n = 0;
    repeat (50) begin @(negedge clk); if (latch_en || coord_ready) n++; end
    check("run low blocks dispatch", n, 0);
    coord_valid = 1'b0;
    available = '0;

    // ---- round-robin vector table, FRAME_PIXELS = 4 ----
    do_reset();
    last_ack = 0;
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < N; i++) if (tbl[k].req[i]) bus_data[i] = word_of(i, tbl[k].iter);
      service_req = tbl[k].req;
      wait_ack(10, ok);
      if (!ok) check("rr ack timeout", 0, 1);
      else begin
        check("rr grant", req_ack, one_n << tbl[k].grant);
        if (k > 0) check("rr ack spacing", cyc - last_ack, 3);
        last_ack = cyc;
        service_req = '0;
        @(negedge clk);
        check("rr ack width", req_ack, 0);
        check("rr fb_we", fb_we, 1);
        check("rr fb_wdata", fb_wdata, word_of(tbl[k].grant, tbl[k].iter));
        check("rr results_cnt", results_cnt, (k + 1) % FP);
        check("rr frame_done", frame_done, ((k + 1) % FP) == 0);
      end
    end

    // ---- back-pressure ----
    fb_full = 1'b1;
    bus_data[2] = word_of(2, 8'h77);
    service_req = 16'h0004;
    n = 0;
    repeat (10) begin @(negedge clk); if (req_ack != '0 || fb_we) n++; end
    check("fb_full blocks grant", n, 0);
    fb_full = 1'b0;
    wait_ack(5, ok);
    if (!ok) check("backpressure ack timeout", 0, 1);
    else begin
      check("backpressure grant", req_ack, 16'h0004);
      service_req = '0;
      fb_full = 1'b1;   // raised after grant: the write must still complete
      @(negedge clk);
      check("backpressure ack width", req_ack, 0);
      check("backpressure fb_we", fb_we, 1);
      check("backpressure fb_wdata", fb_wdata, word_of(2, 8'h77));
      fb_full = 1'b0;
    end

    // ---- reset during R_ACK ----
    @(negedge clk);
    bus_data[1] = word_of(1, 8'h99);
    service_req = 16'h0002;
    wait_ack(10, ok);
    if (!ok) check("reset-ack timeout", 0, 1);
    else begin
      rst_n = 1'b0;
      #1;
      check("async reset req_ack", req_ack, 0);
      check("async reset results_cnt", results_cnt, 0);
      service_req = '0;
      @(negedge clk);
      check("no write after reset", fb_we, 0);
      rst_n = 1'b1;
    end
    bus_data[0]  = word_of(0, 8'h2A);
    bus_data[15] = word_of(15, 8'h2A);
    service_req = 16'h8001;
    wait_ack(10, ok);
    if (!ok) check("post-reset ack timeout", 0, 1);
    else begin
      check("post-reset ptr zero", req_ack, 16'h0001);
      service_req = '0;
      @(negedge clk);
      check("post-reset fb_wdata", fb_wdata, word_of(0, 8'h2A));
      check("post-reset results_cnt", results_cnt, 1);
    end

    // ---- reset during D_STROBE ----
    run = 1'b1; coord_valid = 1'b1; coord_word = c1; available = 16'h0100;
    wait_latch(10, ok);
    if (!ok) check("reset-strobe timeout", 0, 1);
    else begin
      check("pre-reset engine_addr", engine_addr, 8);
      rst_n = 1'b0;
      #1;
      check("async reset latch_en", latch_en, 0);
      check("async reset coord_ready", coord_ready, 0);
      check("async reset engine_addr", engine_addr, 0);
      check("async reset in_word", in_word, 0);
    end

    // ---- randomized run against a transaction model ----
    do_reset();
    d_wait = 0; e_latch = 0; e_addr = '0; e_in = '0;
    e_ack = -1; e_we = 0; e_wdata = '0; m_ptr = 0; e_cnt = 0; e_done = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      check("rnd latch_en", latch_en, e_latch);
      check("rnd coord_ready", coord_ready, e_latch);
      check("rnd engine_addr", engine_addr, e_addr);
      check("rnd in_word", in_word, e_in);
      check("rnd req_ack", req_ack, (e_ack >= 0) ? (one_n << e_ack) : '0);
      check("rnd fb_we", fb_we, e_we);
      check("rnd fb_wdata", fb_wdata, e_wdata);
      check("rnd results_cnt", results_cnt, e_cnt);
      check("rnd frame_done", frame_done, e_done);

      // engines: a granted engine drops its request; idle ones post new results
      if (e_ack >= 0) service_req[e_ack] = 1'b0;
      for (int i = 0; i < N; i++)
        if (!service_req[i] && i != e_ack && $urandom_range(0, 5) == 0) begin
          bus_data[i] = 27'($urandom);
          service_req[i] = 1'b1;
        end
      run         = ($urandom_range(0, 3) != 0);
      coord_valid = ($urandom_range(0, 2) != 0);
      coord_word  = {19'($urandom), 32'($urandom), 32'($urandom)};
      available   = N'($urandom) & N'($urandom);
      fb_full     = ($urandom_range(0, 3) == 0);

      // model outcome of the coming clock edge
      if (d_wait == 0 && run && coord_valid && available != '0) begin
        e_latch = 1'b1;
        e_addr  = AW'(lowest(available));
        e_in    = coord_word;
        d_wait  = 2;
      end else begin
        e_latch = 1'b0;
        if (d_wait > 0) d_wait--;
      end
      if (e_ack >= 0) begin
        e_we    = 1'b1;
        e_wdata = bus_data[e_ack];
        m_ptr   = (e_ack + 1) % N;
        e_cnt   = (e_cnt + 1) % FP;
        e_done  = (e_cnt == 0);
        e_ack   = -1;
      end else begin
        if (!e_we && service_req != '0 && !fb_full) e_ack = rr_pick(service_req, m_ptr);
        e_we   = 1'b0;
        e_done = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
